// File: rtl/axi4_sample_mem_slave.sv
// axi4_sample_mem_slave: AXI4 block-RAM responder with independent write and read FSMs
module axi4_sample_mem_slave #(
    parameter int ID_WIDTH   = 1,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 24,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int MW = $clog2(MEM_WORDS);
    localparam logic [IW-1:0] LIM = IW'(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(3);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    w_state_t              w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic                  w_incr, w_bad, w_err;

    r_state_t              r_state;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic                  r_incr, r_bad;
    logic [DATA_WIDTH-1:0] rd_q;

    logic                  w_hs, w_in, w_ok, w_end, w_err_nxt, aw_bad, ar_bad, r_in;
    logic [ADDR_WIDTH-1:0] w_step, r_step;

    assign w_hs      = s_axi_wvalid & s_axi_wready;
    assign w_in      = w_addr[ADDR_WIDTH-1:2] < LIM;
    assign w_ok      = ~w_bad & w_in;
    assign w_end     = s_axi_wlast | (w_cnt == w_len);
    assign w_err_nxt = w_err | ~w_in | (s_axi_wlast != (w_cnt == w_len));
    assign w_step    = w_incr ? ADDR_WIDTH'(1) << w_size : '0;
    assign aw_bad    = s_axi_awburst[1] | (s_axi_awsize > 3'd2);
    assign ar_bad    = s_axi_arburst[1] | (s_axi_arsize > 3'd2);
    assign r_in      = r_addr[ADDR_WIDTH-1:2] < LIM;
    assign r_step    = r_incr ? ADDR_WIDTH'(1) << r_size : '0;
    assign s_axi_rdata = (s_axi_rvalid && s_axi_rresp == 2'b00) ? rd_q : '0;

    // Write channel: accept AW, absorb W beats, then hold the B response until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= 2'b00;
            w_id          <= '0;
            w_addr        <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_size        <= '0;
            w_incr        <= 1'b0;
            w_bad         <= 1'b0;
            w_err         <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE:
                    if (s_axi_awvalid && s_axi_awready) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_id          <= s_axi_awid;
                        w_addr        <= s_axi_awaddr & ALIGN;
                        w_len         <= s_axi_awlen;
                        w_size        <= s_axi_awsize;
                        w_incr        <= s_axi_awburst == 2'b01;
                        w_bad         <= aw_bad;
                        w_err         <= aw_bad;
                        w_cnt         <= '0;
                        w_state       <= W_DATA;
                    end else begin
                        s_axi_awready <= 1'b1;
                    end
                W_DATA:
                    if (w_hs) begin
                        w_cnt  <= w_cnt + 8'd1;
                        w_addr <= w_addr + w_step;
                        w_err  <= w_err_nxt;
                        if (w_end) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bid    <= w_id;
                            s_axi_bresp  <= w_err_nxt ? 2'b10 : 2'b00;
                            w_state      <= W_RESP;
                        end
                    end
                W_RESP:
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Byte-enabled RAM write for legal in-range beats; contents survive reset
    always_ff @(posedge clk) begin
        if (w_hs && w_ok)
            for (int b = 0; b < DATA_WIDTH/8; b++)
                if (s_axi_wstrb[b]) mem[w_addr[MW+1:2]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end

    // Synchronous RAM read port, loaded during the fetch cycle
    always_ff @(posedge clk) begin
        if (r_state == R_FETCH) rd_q <= mem[r_addr[MW+1:2]];
    end

    // Read channel: accept AR, then fetch/present each beat with one bubble between beats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rresp   <= 2'b00;
            s_axi_rlast   <= 1'b0;
            r_id          <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_size        <= '0;
            r_incr        <= 1'b0;
            r_bad         <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE:
                    if (s_axi_arvalid && s_axi_arready) begin
                        s_axi_arready <= 1'b0;
                        r_id          <= s_axi_arid;
                        r_addr        <= s_axi_araddr & ALIGN;
                        r_len         <= s_axi_arlen;
                        r_size        <= s_axi_arsize;
                        r_incr        <= s_axi_arburst == 2'b01;
                        r_bad         <= ar_bad;
                        r_cnt         <= '0;
                        r_state       <= R_FETCH;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                R_FETCH: begin
                    s_axi_rvalid <= 1'b1;
                    s_axi_rid    <= r_id;
                    s_axi_rlast  <= r_cnt == r_len;
                    s_axi_rresp  <= (r_bad || !r_in) ? 2'b10 : 2'b00;
                    r_state      <= R_DATA;
                end
                R_DATA:
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        if (s_axi_rlast) begin
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_addr  <= r_addr + r_step;
                            r_state <= R_FETCH;
                        end
                    end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_sample_mem_slave.sv
// tb_axi4_sample_mem_slave: directed bench for the AXI4 sample memory responder
module tb_axi4_sample_mem_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [0:0]  awid, bid, arid, rid;
    logic [23:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi4_sample_mem_slave dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_aw(input logic [23:0] a, input logic [7:0] l, input logic [2:0] sz,
                         input logic [1:0] bu, input logic id);
        awaddr = a; awlen = l; awsize = sz; awburst = bu; awid = id; awvalid = 1'b1;
        for (int n = 0; n < 20 && !awready; n++) @(negedge clk);
        chk("aw_ready", awready, 1);
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic l);
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        for (int n = 0; n < 20 && !wready; n++) @(negedge clk);
        chk("w_ready", wready, 1);
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    task automatic do_b(input logic [1:0] er, input logic eid);
        bready = 1'b1;
        for (int n = 0; n < 20 && !bvalid; n++) @(negedge clk);
        chk("b_valid", bvalid, 1);
        chk("b_resp", bresp, er);
        chk("b_id", bid, eid);
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic do_ar(input logic [23:0] a, input logic [7:0] l, input logic [2:0] sz,
                         input logic [1:0] bu, input logic id);
        araddr = a; arlen = l; arsize = sz; arburst = bu; arid = id; arvalid = 1'b1;
        for (int n = 0; n < 20 && !arready; n++) @(negedge clk);
        chk("ar_ready", arready, 1);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic do_r(input logic [31:0] ed, input logic [1:0] er, input logic el, input logic eid);
        rready = 1'b1;
        for (int n = 0; n < 20 && !rvalid; n++) @(negedge clk);
        chk("r_valid", rvalid, 1);
        chk("r_data", rdata, ed);
        chk("r_resp", rresp, er);
        chk("r_last", rlast, el);
        chk("r_id", rid, eid);
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic write1(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er);
        do_aw(a, 8'd0, 3'd2, 2'b01, 1'b0);
        do_w(d, s, 1'b1);
        do_b(er, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
        {wdata, wstrb, wlast, wvalid, bready} = '0;
        {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;
        #1;
        chk("rst_ctrl", {awready, wready, bvalid, arready, rvalid, rlast}, 0);
        chk("rst_data", {rdata, rresp, bresp, rid, bid}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_awready", awready, 1);
        chk("idle_arready", arready, 1);

        // single write/read with latency
        do_aw(24'h000008, 8'd0, 3'd2, 2'b01, 1'b0);
        chk("t1_wready", wready, 1);
        chk("t1_bvalid_early", bvalid, 0);
        do_w(32'hDEADBEEF, 4'hF, 1'b1);
        chk("t1_bvalid", bvalid, 1);
        chk("t1_wready_off", wready, 0);
        do_b(2'b00, 1'b0);
        do_ar(24'h000008, 8'd0, 3'd2, 2'b01, 1'b0);
        chk("t1_rvalid_early", rvalid, 0);
        @(negedge clk);
        chk("t1_rvalid", rvalid, 1);
        do_r(32'hDEADBEEF, 2'b00, 1'b1, 1'b0);

        // byte strobes
        write1(24'h000010, 32'hFFFFFFFF, 4'hF, 2'b00);
        write1(24'h000010, 32'h12345678, 4'h3, 2'b00);
        do_ar(24'h000010, 8'd0, 3'd2, 2'b01, 1'b0);
        do_r(32'hFFFF5678, 2'b00, 1'b1, 1'b0);

        // INCR burst with read stalls
        do_aw(24'h000020, 8'd3, 3'd2, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) do_w(32'(i + 1), 4'hF, i == 3);
        do_b(2'b00, 1'b1);
        do_ar(24'h000020, 8'd3, 3'd2, 2'b01, 1'b1);
        for (int i = 0; i < 4; i++) begin
            for (int n = 0; n < 20 && !rvalid; n++) @(negedge clk);
            chk("t3_first", rdata, 32'(i + 1));
            @(negedge clk);
            chk("t3_held_data", rdata, 32'(i + 1));
            chk("t3_held_valid", rvalid, 1);
            do_r(32'(i + 1), 2'b00, i == 3, 1'b1);
        end

        // out-of-range word must not alias onto word 0
        write1(24'h000000, 32'hA5A5A5A5, 4'hF, 2'b00);
        write1(24'h001000, 32'hBAD0BAD0, 4'hF, 2'b10);
        do_ar(24'h000000, 8'd0, 3'd2, 2'b01, 1'b0);
        do_r(32'hA5A5A5A5, 2'b00, 1'b1, 1'b0);
        do_ar(24'h001000, 8'd0, 3'd2, 2'b01, 1'b0);
        do_r(32'h0, 2'b10, 1'b1, 1'b0);

        // B backpressure
        do_aw(24'h000030, 8'd0, 3'd2, 2'b01, 1'b1);
        do_w(32'h0BADCAFE, 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t5_bvalid", bvalid, 1);
            chk("t5_bid", bid, 1);
            chk("t5_bresp", bresp, 0);
            chk("t5_awready", awready, 0);
            @(negedge clk);
        end
        do_b(2'b00, 1'b1);
        chk("t5_awready_after", awready, 1);

        // early wlast: error response, beat still committed
        do_aw(24'h000050, 8'd1, 3'd2, 2'b01, 1'b0);
        do_w(32'h00000055, 4'hF, 1'b1);
        do_b(2'b10, 1'b0);
        do_ar(24'h000050, 8'd0, 3'd2, 2'b01, 1'b0);
        do_r(32'h00000055, 2'b00, 1'b1, 1'b0);

        // WRAP read: every beat errors, full length kept
        do_ar(24'h000008, 8'd1, 3'd2, 2'b10, 1'b1);
        do_r(32'h0, 2'b10, 1'b0, 1'b1);
        do_r(32'h0, 2'b10, 1'b1, 1'b1);

        // reset in the middle of a write burst
        do_aw(24'h000040, 8'd3, 3'd2, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) do_w(32'hA0 + 32'(i), 4'hF, i == 3);
        do_b(2'b00, 1'b0);
        do_aw(24'h000040, 8'd3, 3'd2, 2'b01, 1'b0);
        do_w(32'hB0, 4'hF, 1'b0);
        do_w(32'hB1, 4'hF, 1'b0);
        wdata = 32'hB2; wvalid = 1'b1; rst = 1'b1;
        #1;
        chk("t6_rst_ctrl", {awready, wready, bvalid, arready, rvalid, rlast}, 0);
        chk("t6_rst_data", {rdata, rresp, bresp, rid, bid}, 0);
        @(negedge clk);
        wvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_awready", awready, 1);
        do_ar(24'h000040, 8'd3, 3'd2, 2'b01, 1'b0);
        do_r(32'hB0, 2'b00, 1'b0, 1'b0);
        do_r(32'hB1, 2'b00, 1'b0, 1'b0);
        do_r(32'hA2, 2'b00, 1'b0, 1'b0);
        do_r(32'hA3, 2'b00, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi4_sample_mem_slave.md
Name: axi4_sample_mem_slave

Overview:
- AXI4-Full responder backed by on-chip block RAM, used as a drop-in sample buffer in place of the PSRAM controller.
- Accepts the write and read transactions issued by the mic capture/playback logic: single beats and INCR/FIXED bursts.
- Also serves as the bus-functional target for benches that exercise the capture initiator.
- Write and read channels run as independent state machines sharing one memory array.

Parameters:
- ID_WIDTH, 1, width of AWID/BID/ARID/RID.
- DATA_WIDTH, 32, data bus width in bits; fixed at 32 for this block.
- ADDR_WIDTH, 24, byte address width.
- MEM_WORDS, 1024, number of 32-bit words implemented; word index = addr[ADDR_WIDTH-1:2].

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous reset, active-high.
- s_axi_awid  in  ID_WIDTH  write ID.
- s_axi_awaddr  in  ADDR_WIDTH  write byte address.
- s_axi_awlen  in  8  beats minus one.
- s_axi_awsize  in  3  bytes per beat, log2.
- s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
- s_axi_awvalid / s_axi_awready  in/out  1  AW handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_wvalid / s_axi_wready  in/out  1  W handshake.
- s_axi_bid  out  ID_WIDTH  response ID.
- s_axi_bresp  out  2  00 OKAY, 10 SLVERR.
- s_axi_bvalid / s_axi_bready  out/in  1  B handshake.
- s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst  in  as AW equivalents.
- s_axi_arvalid / s_axi_arready  in/out  1  AR handshake.
- s_axi_rid  out  ID_WIDTH  read ID.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  per-beat response.
- s_axi_rlast  out  1  last read beat.
- s_axi_rvalid / s_axi_rready  out/in  1  R handshake.
- Lock/cache/prot/qos/region/user signals are not implemented; the initiator ties them off.

Behaviour:
- Reset: clk single clock domain; rst asynchronous, active-high. While rst=1, every output is 0, both FSMs are IDLE and the beat counters are 0. Memory contents are not reset.
- Write FSM states:
  - W_IDLE: awready=1, wready=0. On awvalid&awready, latch id, addr aligned down to 4 bytes, len, size and burst; go to W_DATA.
  - W_DATA: awready=0, wready=1. Each wvalid&wready beat writes the addressed word byte-wise per wstrb. The write occurs only if the word index < MEM_WORDS and the burst is legal. The beat counter increments.
  - Exit W_DATA on the beat where wlast=1 or the counter equals len, whichever comes first, then go to W_RESP.
  - W_RESP: wready=0, bvalid=1, bid=latched id. Hold bvalid, bid and bresp until bready; then go to W_IDLE.
  - Minimum latency: AW accept at cycle N, single W beat at N+1, bvalid at N+2.
- Write address update: INCR adds 1<<size per beat; FIXED holds the address.
- Write error sticky flag, cleared at AW accept; any of the following sets it and gives bresp=10:
  - burst=WRAP;
  - size>2;
  - any beat whose word index >= MEM_WORDS;
  - wlast position not equal to len (early wlast or missing wlast).
- Write errors: bresp=10 when the flag is set, else 00. Illegal beats are dropped and legal beats still commit.
- Read FSM states:
  - R_IDLE: arready=1. On AR handshake, latch fields (address aligned down) and go to R_FETCH.
  - R_FETCH: arready=0, one cycle of synchronous RAM read; go to R_DATA.
  - R_DATA: rvalid=1, with rdata, rresp, rid and rlast stable while rvalid&~rready.
  - On rvalid&rready: if rlast, go to R_IDLE. Otherwise advance the address and return to R_FETCH, giving one bubble per beat.
  - rlast=1 exactly on beat index len.
- Read latency: AR accept at N, first rvalid at N+2.
- Read errors:
  - Beat with word index >= MEM_WORDS: rdata=0, rresp=10.
  - Burst WRAP or size>2: every beat returns rdata=0, rresp=10, still len+1 beats.
- Concurrency: read and write FSMs run concurrently. A read fetch of a word written in the same cycle returns the pre-write (old) value.
- Address arithmetic: ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH. The word index is compared against MEM_WORDS after wrap.
- Reset mid-burst: any in-flight transaction is abandoned with no response. Partial writes already committed remain in memory.

Test Plan:
- AW addr=0x000008 len=0, W 0xDEADBEEF strb=1111 wlast=1, then AR addr=0x000008 -> bvalid 2 cycles after AW, bresp=00; rdata=0xDEADBEEF, rresp=00, rlast=1, rvalid 2 cycles after AR.
- Write 0xFFFFFFFF to 0x10, then 0x12345678 strb=0011 to 0x10 -> readback 0xFFFF5678.
- INCR burst awlen=3 at 0x20 with data 1,2,3,4, then AR len=3 with rready toggling 1,0,1,0 -> data 1,2,3,4 in order, rlast only on 4th beat, rdata held during stalls.
- Write to word index MEM_WORDS (addr 0x001000) -> bresp=10, memory unchanged; read the same address -> rdata=0, rresp=10.
- bready held 0 for 5 cycles after bvalid -> bvalid, bid, bresp stable, awready=0 until B handshake, awready=1 the next cycle.
- Assert rst during beat 2 of a len=3 write burst, release, then read the 4 words -> beats 0-1 hold new data, beats 2-3 hold old data; all outputs 0 during rst; awready=1 the first cycle after release.
